// File: rtl/uram_spram_pipe.sv
// Single-port URAM scratchpad: valid/ready requests, byte-lane writes, tagged read pipeline.
// Define URAM_SPRAM_CLEAR_EN to build the zero-fill engine that sweeps the array after reset or clear_start.
module uram_spram_pipe #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 128,
    parameter int BYTE_W = 8,
    parameter int RD_LAT = 1,
    parameter int TAG_W  = 4
) (
    input  logic                       clka,
    input  logic                       rsta_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [DATA_W/BYTE_W-1:0]   req_we,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [TAG_W-1:0]           req_tag,
    output logic                       rsp_valid,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic [TAG_W-1:0]           rsp_tag,
    input  logic                       clear_start,
    output logic                       clear_busy
);

    localparam int NB    = DATA_W / BYTE_W;
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [DATA_W-1:0] rd_q_r;

    logic              ready_s;
    logic              clr_act_s;
    logic [ADDR_W-1:0] clr_addr_s;
    logic              acc_s;
    logic              rd_acc_s;
    logic [NB-1:0]     wr_be_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;

`ifdef URAM_SPRAM_CLEAR_EN
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } clr_state_t;

    clr_state_t        state_r;
    logic [ADDR_W-1:0] cnt_r;
    logic              ready_r;
    logic              busy_r;

    // Clear sequencer; ready/busy are registered alongside the state so they always mirror it.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            state_r <= ST_CLEAR;
            cnt_r   <= {ADDR_W{1'b0}};
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r <= {ADDR_W{1'b0}};
                    if (clear_start) begin
                        state_r <= ST_CLEAR;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    cnt_r <= cnt_r + ADDR_W'(1);
                    if (cnt_r == {ADDR_W{1'b1}}) begin
                        state_r <= ST_IDLE;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        state_r <= ST_CLEAR;
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    cnt_r   <= {ADDR_W{1'b0}};
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign ready_s    = ready_r;
    assign clr_act_s  = busy_r;
    assign clr_addr_s = cnt_r;
`else
    logic unused_clear_s;

    assign unused_clear_s = clear_start;
    assign ready_s        = 1'b1;
    assign clr_act_s      = 1'b0;
    assign clr_addr_s     = {ADDR_W{1'b0}};
`endif

    assign req_ready  = ready_s;
    assign clear_busy = clr_act_s;

    assign acc_s    = req_valid & ready_s;
    assign rd_acc_s = acc_s & (req_we == {NB{1'b0}});

    // Single write port shared between the clear sweep and accepted requests.
    always_comb begin
        wr_be_s   = {NB{1'b0}};
        wr_addr_s = req_addr;
        wr_data_s = req_wdata;
        if (clr_act_s) begin
            wr_be_s   = {NB{1'b1}};
            wr_addr_s = clr_addr_s;
            wr_data_s = {DATA_W{1'b0}};
        end else if (acc_s) begin
            wr_be_s   = req_we;
            wr_addr_s = req_addr;
            wr_data_s = req_wdata;
        end else begin
            wr_be_s   = {NB{1'b0}};
            wr_addr_s = req_addr;
            wr_data_s = req_wdata;
        end
    end

    // Array and its read register; contents are deliberately never reset.
    always_ff @(posedge clka) begin
        for (int l = 0; l < NB; l++) begin
            if (wr_be_s[l]) begin
                mem_r[wr_addr_s][l*BYTE_W +: BYTE_W] <= wr_data_s[l*BYTE_W +: BYTE_W];
            end
        end
        if (rd_acc_s) begin
            rd_q_r <= mem_r[req_addr];
        end
    end

    logic [RD_LAT:0]   vld_r;
    logic [TAG_W-1:0]  tag_r [RD_LAT+1];
    logic [DATA_W-1:0] dat_r [1:RD_LAT];

    // Response pipeline; each stage only advances with a valid, so the output holds its last word.
    always_ff @(posedge clka or negedge rsta_n) begin
        if (!rsta_n) begin
            vld_r <= {(RD_LAT+1){1'b0}};
            for (int k = 0; k <= RD_LAT; k++) begin
                tag_r[k] <= {TAG_W{1'b0}};
            end
            for (int k = 1; k <= RD_LAT; k++) begin
                dat_r[k] <= {DATA_W{1'b0}};
            end
        end else begin
            vld_r[0] <= rd_acc_s;
            if (rd_acc_s) begin
                tag_r[0] <= req_tag;
            end
            vld_r[1] <= vld_r[0];
            if (vld_r[0]) begin
                tag_r[1] <= tag_r[0];
                dat_r[1] <= rd_q_r;
            end
            for (int k = 2; k <= RD_LAT; k++) begin
                vld_r[k] <= vld_r[k-1];
                if (vld_r[k-1]) begin
                    tag_r[k] <= tag_r[k-1];
                    dat_r[k] <= dat_r[k-1];
                end
            end
        end
    end

    assign rsp_valid = vld_r[RD_LAT];
    assign rsp_rdata = dat_r[RD_LAT];
    assign rsp_tag   = tag_r[RD_LAT];

endmodule

// File: tb/tb_uram_spram_pipe.sv
// Directed bench for uram_spram_pipe with a cycle-level reference model of memory, clear sweep and responses.
module tb_uram_spram_pipe;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int BW = 8;
    localparam int RL = 3;
    localparam int TW = 4;
    localparam int NB = DW / BW;
`ifdef URAM_SPRAM_CLEAR_EN
    localparam int CLR_N = 16;
`else
    localparam int CLR_N = 0;
`endif

    logic          clka;
    logic          rsta_n;
    logic          req_valid;
    logic          req_ready;
    logic [NB-1:0] req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic [TW-1:0] req_tag;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic [TW-1:0] rsp_tag;
    logic          clear_start;
    logic          clear_busy;

    uram_spram_pipe #(.ADDR_W(AW), .DATA_W(DW), .BYTE_W(BW), .RD_LAT(RL), .TAG_W(TW)) dut (
        .clka(clka), .rsta_n(rsta_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_tag(rsp_tag),
        .clear_start(clear_start), .clear_busy(clear_busy)
    );

    initial clka = 1'b0;
    always #5 clka = ~clka;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: memory image, remaining clear cycles, queue of due responses.
    typedef struct {
        int            due;
        logic [DW-1:0] d;
        logic [TW-1:0] t;
    } rsp_t;

    logic [DW-1:0] mem_m [16];
    rsp_t          q [$];
    int            ecyc    = 0;
    int            clr_left = CLR_N;
    logic [DW-1:0] last_d  = '0;
    logic [TW-1:0] last_t  = '0;

    initial begin
        logic exp_v;
        rsp_t r;
        for (int i = 0; i < 16; i++) mem_m[i] = 'x;
        forever begin
            @(negedge clka);
            if (!rsta_n) begin
                q.delete();
                clr_left = CLR_N;
                last_d = '0;
                last_t = '0;
            end
            exp_v = (q.size() > 0) && (q[0].due == ecyc);
            if (exp_v) begin
                r = q.pop_front();
                last_d = r.d;
                last_t = r.t;
            end
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_v));
            chk("rsp_rdata", 64'(rsp_rdata), 64'(last_d));
            if (exp_v || !rsta_n) chk("rsp_tag", 64'(rsp_tag), 64'(last_t));
            chk("req_ready", 64'(req_ready), 64'(clr_left == 0));
            chk("clear_busy", 64'(clear_busy), 64'(clr_left != 0));
            // predict the effect of the coming rising edge
            ecyc++;
            if (rsta_n) begin
                if (clr_left == 0 && req_valid) begin
                    if (req_we != '0) begin
                        for (int l = 0; l < NB; l++)
                            if (req_we[l]) mem_m[req_addr][l*BW +: BW] = req_wdata[l*BW +: BW];
                    end else begin
                        q.push_back('{due: ecyc + RL, d: mem_m[req_addr], t: req_tag});
                    end
                end
                if (clr_left > 0) begin
                    mem_m[16 - clr_left] = '0;
                    clr_left--;
                end else if (clear_start) begin
                    clr_left = CLR_N;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic req(input logic [NB-1:0] we, input int a, input logic [DW-1:0] d,
                       input int t, input logic clr);
        req_valid   = 1'b1;
        req_we      = we;
        req_addr    = AW'(a);
        req_wdata   = d;
        req_tag     = TW'(t);
        clear_start = clr;
        tick();
        req_valid   = 1'b0;
        req_we      = '0;
        clear_start = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 200) begin
            tick();
            n++;
        end
    endtask

    // Read with a literal expectation exactly RL cycles after acceptance.
    task automatic read_pin(input int a, input int t, input logic [DW-1:0] exp, input string name);
        req('0, a, '0, t, 1'b0);
        repeat (RL - 1) @(posedge clka);
        @(negedge clka);
        chk({name, "_early"}, 64'(rsp_valid), 64'(0));
        @(posedge clka);
        @(negedge clka);
        chk({name, "_valid"}, 64'(rsp_valid), 64'(1));
        chk({name, "_data"}, 64'(rsp_rdata), 64'(exp));
        chk({name, "_tag"}, 64'(rsp_tag), 64'(t));
    endtask

    initial begin
        int n;
        int seen;
        rsta_n = 1'b0; req_valid = 1'b0; req_we = '0; req_addr = '0;
        req_wdata = '0; req_tag = '0; clear_start = 1'b0;
        repeat (3) tick();
        chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("rst_rsp_rdata", 64'(rsp_rdata), 64'(0));
        chk("rst_rsp_tag", 64'(rsp_tag), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(CLR_N == 0));
        chk("rst_clear_busy", 64'(clear_busy), 64'(CLR_N != 0));
        rsta_n = 1'b1;
        wait_ready(n);
        chk("init_clear_cycles", 64'(n), 64'(CLR_N));
`ifndef URAM_SPRAM_CLEAR_EN
        for (int i = 0; i < 16; i++) req('1, i, '0, 0, 1'b0);
`endif
        // back-to-back reads, one per cycle, tags = address
        for (int i = 0; i < 16; i++) req('0, i, '0, i, 1'b0);
        repeat (RL + 2) tick();

        req(4'b1111, 5, 32'hDEADBEEF, 0, 1'b0);
        req(4'b0101, 5, 32'h11223344, 0, 1'b0);
        read_pin(5, 7, 32'hDE22BE44, "merge");
        tick();

        req(4'b1111, 3, 32'hA5A5A5A5, 0, 1'b0);
        read_pin(3, 2, 32'hA5A5A5A5, "fwd");
        tick();

        for (int i = 0; i < 16; i++) req('1, i, {4{8'(i * 17 + 1)}}, 0, 1'b0);
        req('0, 8, '0, 4, 1'b0);
        req('0, 9, '0, 5, 1'b1);
        repeat (5) tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        wait_ready(n);
        chk("restart_ignored", 64'(n), 64'((CLR_N > 0) ? CLR_N - 6 : 0));
        for (int i = 0; i < 16; i++) req('0, i, '0, 15 - i, 1'b0);
        repeat (RL + 2) tick();

        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        repeat (6) tick();
        rsta_n = 1'b0;
        tick();
        rsta_n = 1'b1;
        wait_ready(n);
        chk("reset_mid_clear", 64'(n), 64'(CLR_N));

        req(4'b1111, 1, 32'hCAFEF00D, 0, 1'b0);
        req('0, 1, '0, 9, 1'b0);
        req('0, 2, '0, 10, 1'b0);
        rsta_n = 1'b0;
        seen = 0;
        for (int i = 0; i < RL + 3; i++) begin
            @(negedge clka);
            if (rsp_valid) seen++;
        end
        chk("inflight_dropped", 64'(seen), 64'(0));
        tick();
        rsta_n = 1'b1;
        wait_ready(n);
        chk("post_reset_clear", 64'(n), 64'(CLR_N));
        req(4'b0011, 6, 32'h0000BEEF, 0, 1'b0);
        read_pin(6, 12, (CLR_N > 0) ? 32'h0000BEEF : {mem_m[6][31:16], 16'hBEEF}, "post");
        repeat (RL + 2) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uram_spram_pipe.md
# uram_spram_pipe

Parametrised single-port UltraRAM scratchpad with a valid/ready request port, per-byte write enables, a configurable read pipeline returning tagged responses, and an optional hardware clear engine that zeroes the array after reset or on demand. It replaces fixed-geometry URAM wrappers in the hashing datapath, where the scratchpad must start from a known zero state before each job. Array contents are never reset by `rsta_n`. Only the control state, pipeline valids and outputs are reset.

## Interface
- `ADDR_W`, 15: address width. Depth is 2^ADDR_W words.
- `DATA_W`, 128: word width. Must be a multiple of `BYTE_W`.
- `BYTE_W`, 8: byte-lane width. NB = DATA_W/BYTE_W lanes.
- `RD_LAT`, 1: read latency in cycles, legal range 1..4. Stages beyond 1 are output registers.
- `TAG_W`, 4: width of the request tag echoed on read responses.

Ports:
- `clka` in 1: the single clock.
- `rsta_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted.
- `req_we` in NB: per-lane write enable. All-zero means a read.
- `req_addr` in ADDR_W: word address.
- `req_wdata` in DATA_W: write data.
- `req_tag` in TAG_W: tag returned with the read data.
- `rsp_valid` out 1: one-cycle pulse when read data is valid.
- `rsp_rdata` out DATA_W: read data.
- `rsp_tag` out TAG_W: tag of the returned read.
- `clear_start` in 1: pulse that requests a full-array clear.
- `clear_busy` out 1: clear engine is active.

## Operation
- A request is accepted when `req_valid & req_ready` at a `clka` rising edge.
- Write (`req_we` ≠ 0):
  - Only the enabled lanes are updated. Disabled lanes keep their old contents.
  - No response is produced.
- Read (`req_we` = 0):
  - The word at `req_addr` is returned together with `req_tag`.
  - Responses come back in acceptance order.
  - There is no response backpressure; the consumer must always sink responses.
- A read accepted in the cycle after a write to the same address returns the written data.
- Clear engine FSM, states IDLE and CLEAR:
  - Asserting `rsta_n` low forces CLEAR with the address counter at 0.
  - In CLEAR, one all-lanes zero write per cycle is issued at the counter address, and the counter increments.
  - After address 2^ADDR_W−1 is written, the FSM returns to IDLE. The counter wraps to 0.
  - `clear_start` sampled high in IDLE moves the FSM to CLEAR with the counter at 0.
  - `clear_start` during CLEAR is ignored.
- `req_ready` = (state == IDLE). `clear_busy` = (state == CLEAR).
- Reads accepted before CLEAR is entered complete normally and return pre-clear data.
- Reset mid-clear aborts the sweep and clears all pipeline valids. The sweep restarts from address 0 after release.

## Timing
- Reset values:
  - `rsp_valid` = 0, `rsp_rdata` = 0, `rsp_tag` = 0.
  - `req_ready` = 0 and `clear_busy` = 1 with the macro. `req_ready` = 1 and `clear_busy` = 0 without it.
- Read accepted at edge N: `rsp_valid`, `rsp_rdata` and `rsp_tag` are valid for exactly the cycle after edge N+RD_LAT.
- Throughput is one request per cycle, with back-to-back reads fully pipelined.
- A full clear takes 2^ADDR_W cycles from entering CLEAR to `req_ready` rising.
- `rsp_rdata` holds its last value when `rsp_valid` = 0.

## Configuration
- Macro: `URAM_SPRAM_CLEAR_EN`.
- Defined:
  - The clear FSM and counter are built.
  - The array is zeroed automatically after every reset and on each `clear_start` pulse.
- Undefined:
  - No FSM or counter is built.
  - `req_ready` is tied 1, `clear_busy` is tied 0, and `clear_start` is ignored.
  - Array contents after power-up are undefined.

## Test plan
Use ADDR_W=4, DATA_W=32, BYTE_W=8 and RD_LAT=3 unless noted.
- Reset release with the macro -> `clear_busy`=1 and `req_ready`=0 for 16 cycles. Reads of all 16 addresses then return 0x00000000.
- Write 0xDEADBEEF to addr 5, then write 0x11223344 with `req_we`=4'b0101 to addr 5, then read with tag 0x7 -> exactly 3 cycles after the read is accepted, `rsp_valid`=1, `rsp_rdata`=0xDE22BE44, `rsp_tag`=0x7.
- Back-to-back reads of addrs 0..15 with tags 0..15 -> 16 consecutive `rsp_valid` cycles, in order, with tags matching.
- Write addr 3 = 0xA5A5A5A5, then read addr 3 on the next cycle -> 0xA5A5A5A5 returned.
- `clear_start` pulse after filling the array -> 16 busy cycles, then all reads return 0. A second `clear_start` pulse mid-sweep adds no extra cycles.
- `rsta_n` pulsed low at clear cycle 7 -> sweep restarts, giving 16 busy cycles after release. No `rsp_valid` is emitted for reads that were in flight at reset.
